mem_ring_arbiter: RTL and testbench
===================================

MEM_RING_ARBITER -- requirements
Module: mem_ring_arbiter

Interface
REQ-001 Parameter RING1_START, default 16'h00, first memory word of ring 1.
REQ-002 Parameter RING1_END, default 16'h7F, last memory word of ring 1.
REQ-003 Parameter RING2_START, default 16'h80, first memory word of ring 2.
REQ-004 Parameter RING2_END, default 16'hFF, last memory word of ring 2.
REQ-005 Parameter MEM_RD_LATENCY, default 2, cycles from mem_re to valid mem_rdata.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 clr1, clr2  in  1  ring clear commands (one-cycle pulse).
REQ-009 wr_req1, wr_req2  in  1  write request, held with wr_data until wr_ack.
REQ-010 wr_data1, wr_data2  in  16  word to store.
REQ-011 wr_ack1, wr_ack2  out  1  one-cycle pulse: write committed.
REQ-012 rd_req1, rd_req2  in  1  read request, held until rd_ack.
REQ-013 rd_ack1, rd_ack2  out  1  one-cycle pulse: read issued to memory.
REQ-014 rd_data1, rd_data2  out  16  read word.
REQ-015 rd_valid1, rd_valid2  out  1  one-cycle pulse: rd_data valid.
REQ-016 count1, count2  out  16  words stored per ring.
REQ-017 full1, full2, empty1, empty2  out  1  ring status.
REQ-018 mem_addr  out  16; mem_wdata  out  16; mem_we  out  1; mem_re  out  1; mem_rdata  in  16 -- single-port memory bus.

Function
REQ-019 Capacity per ring SHALL be END-START+1; full = (count==capacity), empty = (count==0), both registered.
REQ-020 Clients SHALL be, in index order: R1_WR, R1_RD, R2_WR, R2_RD; client eligible = req and (write: not full; read: not empty).
REQ-021 FSM SHALL have states IDLE, ACCESS, RD_WAIT.
REQ-022 IDLE: if any client eligible, select first eligible at or after round-robin pointer, register selection, go ACCESS; else stay.
REQ-023 ACCESS (exactly one cycle): drive mem_addr = ring pointer; write -> mem_we=1, mem_wdata=wr_data, wr_ack pulse, wptr/count update, go IDLE; read -> mem_re=1, rd_ack pulse, rptr/count update, go RD_WAIT.
REQ-024 Round-robin pointer SHALL move to client after granted one, in ACCESS.
REQ-025 RD_WAIT: wait MEM_RD_LATENCY cycles; if mem_re in cycle N, capture mem_rdata of cycle N+MEM_RD_LATENCY, rd_data/rd_valid high in cycle N+MEM_RD_LATENCY+1, same cycle return IDLE.
REQ-026 Pointer equal to END SHALL wrap to START on increment; count never exceeds capacity nor goes below 0.
REQ-027 mem_we and mem_re SHALL never be high together; both 0 outside ACCESS.
REQ-028 Selection committed in IDLE is executed even if req drops in ACCESS.
REQ-029 clrN SHALL set that ring's wptr=rptr=START, count=0 next cycle, overriding a same-cycle update of that ring.
REQ-030 clrN during RD_WAIT for ring N SHALL suppress rd_validN; FSM still returns IDLE on schedule.
REQ-031 Throughput: write every 2 cycles, read every MEM_RD_LATENCY+2 cycles.

Reset
REQ-032 rst SHALL force IDLE, pointers=START, count=0, empty=1, full=0, rr pointer=R1_WR, all acks/valids/mem_we/mem_re=0, rd_data=0, mem_addr=0, mem_wdata=0; mid-access rst aborts without rd_valid.

Structure
REQ-033 Shared package (milStd1553 companion, e.g. memRingPkg) SHALL hold client enum, FSM state typedef, 16-bit word type.
REQ-034 Sub-module ring_pointer (wptr, rptr, count, full, empty, wrap, clear) SHALL be instantiated twice.

Verification
REQ-035 Write 16'hEFAB to ring1, then read -> mem_we addr 0x00 data EFAB; mem_re addr 0x00; rd_data1=EFAB, rd_valid1 3 cycles after mem_re; count1 1->0.
REQ-036 128 writes to ring1 -> count1=0x80, full1=1; 129th wr_req1 not acked until one read; then acked at addr 0x00 (wrap).
REQ-037 All four reqs high from reset -> grant order R1_WR(0x00), R1_RD(0x00), R2_WR(0x80), R2_RD(0x80).
REQ-038 rd_req2 on empty ring2 -> no rd_ack2, no mem_re; served after wr_req2 of 16'h9D4D, rd_data2=9D4D.
REQ-039 clr1 during RD_WAIT of ring1 read -> no rd_valid1, count1=0, next write at 0x00.
REQ-040 rst in ACCESS of a write -> outputs at reset values next cycle, count=0.

Source files
------------

// File: rtl/mem_ring_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ring_arbiter_pkg
// Description : Shared types for the two-ring memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ring_arbiter_pkg;

   typedef logic [15:0] word_t;

   // Client index order doubles as the round-robin order.
   typedef enum logic [1:0] {
      R1_WR = 2'd0,
      R1_RD = 2'd1,
      R2_WR = 2'd2,
      R2_RD = 2'd3
   } client_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RD_WAIT = 2'd2
   } state_e;

   localparam int c_num_clients = 4;

   function automatic logic is_read(input client_e c);
      logic [1:0] v;
      v = c;
      return v[0];
   endfunction

   function automatic logic is_ring2(input client_e c);
      logic [1:0] v;
      v = c;
      return v[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ring_arbiter_ring_pointer.sv
`default_nettype none
// ============================================================================
// Module      : mem_ring_arbiter_ring_pointer
// Description : Write/read pointers, fill count and full/empty for one ring.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ring_arbiter_ring_pointer
   import mem_ring_arbiter_pkg::*;
#(
   parameter word_t RING_START = 16'h0000,
   parameter word_t RING_END   = 16'h007F
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  clr,
   input  logic  inc_w,
   input  logic  inc_r,
   output word_t wptr,
   output word_t rptr,
   output word_t count,
   output logic  full,
   output logic  empty
);

   localparam word_t c_capacity = RING_END - RING_START + 16'd1;

   word_t r_wptr, r_rptr, r_count, w_count_nxt;
   logic  r_full, r_empty, w_do_w, w_do_r;

   function automatic word_t bump(input word_t p);
      return (p == RING_END) ? RING_START : p + 16'd1;
   endfunction

   // Guards keep the count in range even if a committed access outlives its flag.
   assign w_do_w = inc_w && (r_count != c_capacity);
   assign w_do_r = inc_r && (r_count != '0);

   always_comb begin
      w_count_nxt = r_count;
      if (w_do_w && !w_do_r)
         w_count_nxt = r_count + 16'd1;
      else if (w_do_r && !w_do_w)
         w_count_nxt = r_count - 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_wptr  <= RING_START;
         r_rptr  <= RING_START;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_do_w)
            r_wptr <= bump(r_wptr);
         if (w_do_r)
            r_rptr <= bump(r_rptr);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == c_capacity);
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign wptr  = r_wptr;
   assign rptr  = r_rptr;
   assign count = r_count;
   assign full  = r_full;
   assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/mem_ring_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_ring_arbiter
// Description : Round-robin arbiter of two ring buffers onto one memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ring_arbiter
   import mem_ring_arbiter_pkg::*;
#(
   parameter word_t RING1_START    = 16'h0000,
   parameter word_t RING1_END      = 16'h007F,
   parameter word_t RING2_START    = 16'h0080,
   parameter word_t RING2_END      = 16'h00FF,
   parameter int    MEM_RD_LATENCY = 2
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  clr1,
   input  logic  clr2,
   input  logic  wr_req1,
   input  logic  wr_req2,
   input  word_t wr_data1,
   input  word_t wr_data2,
   output logic  wr_ack1,
   output logic  wr_ack2,
   input  logic  rd_req1,
   input  logic  rd_req2,
   output logic  rd_ack1,
   output logic  rd_ack2,
   output word_t rd_data1,
   output word_t rd_data2,
   output logic  rd_valid1,
   output logic  rd_valid2,
   output word_t count1,
   output word_t count2,
   output logic  full1,
   output logic  full2,
   output logic  empty1,
   output logic  empty2,
   output word_t mem_addr,
   output word_t mem_wdata,
   output logic  mem_we,
   output logic  mem_re,
   input  word_t mem_rdata
);

   state_e     r_state, w_state_nxt;
   client_e    r_sel, w_sel_nxt, r_rr, w_pick;
   logic [7:0] r_wait;
   logic [3:0] w_elig;
   logic [1:0] w_idx;
   logic       r_kill, w_found, w_clr_sel, w_rd_done, w_access;
   logic       r_rd_valid1, r_rd_valid2;
   word_t      r_rd_data1, r_rd_data2;
   word_t      w_wptr1, w_rptr1, w_wptr2, w_rptr2;

   assign w_access  = (r_state == ACCESS);
   assign w_elig    = {rd_req2 && !empty2, wr_req2 && !full2, rd_req1 && !empty1, wr_req1 && !full1};
   assign w_clr_sel = is_ring2(r_sel) ? clr2 : clr1;
   assign w_rd_done = (r_state == RD_WAIT) && (r_wait == 8'(MEM_RD_LATENCY - 1));

   mem_ring_arbiter_ring_pointer #(
      .RING_START (RING1_START),
      .RING_END   (RING1_END)
   ) u_ring_pointer1 (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr1),
      .inc_w (w_access && (r_sel == R1_WR)),
      .inc_r (w_access && (r_sel == R1_RD)),
      .wptr  (w_wptr1),
      .rptr  (w_rptr1),
      .count (count1),
      .full  (full1),
      .empty (empty1)
   );

   mem_ring_arbiter_ring_pointer #(
      .RING_START (RING2_START),
      .RING_END   (RING2_END)
   ) u_ring_pointer2 (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr2),
      .inc_w (w_access && (r_sel == R2_WR)),
      .inc_r (w_access && (r_sel == R2_RD)),
      .wptr  (w_wptr2),
      .rptr  (w_rptr2),
      .count (count2),
      .full  (full2),
      .empty (empty2)
   );

   // First eligible client at or after the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr;
      w_idx   = r_rr;
      for (int i = 0; i < c_num_clients; i++) begin
         w_idx = r_rr + 2'(i);
         if (!w_found && w_elig[w_idx]) begin
            w_found = 1'b1;
            w_pick  = client_e'(w_idx);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      wr_ack1     = 1'b0;
      wr_ack2     = 1'b0;
      rd_ack1     = 1'b0;
      rd_ack2     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_sel_nxt   = w_pick;
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            case (r_sel)
               R1_WR: begin
                  mem_addr  = w_wptr1;
                  mem_wdata = wr_data1;
                  mem_we    = 1'b1;
                  wr_ack1   = 1'b1;
               end
               R1_RD: begin
                  mem_addr = w_rptr1;
                  mem_re   = 1'b1;
                  rd_ack1  = 1'b1;
               end
               R2_WR: begin
                  mem_addr  = w_wptr2;
                  mem_wdata = wr_data2;
                  mem_we    = 1'b1;
                  wr_ack2   = 1'b1;
               end
               default: begin
                  mem_addr = w_rptr2;
                  mem_re   = 1'b1;
                  rd_ack2  = 1'b1;
               end
            endcase
            w_state_nxt = is_read(r_sel) ? RD_WAIT : IDLE;
         end
         RD_WAIT: begin
            if (w_rd_done)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_sel       <= R1_WR;
         r_rr        <= R1_WR;
         r_wait      <= '0;
         r_kill      <= 1'b0;
         r_rd_data1  <= '0;
         r_rd_data2  <= '0;
         r_rd_valid1 <= 1'b0;
         r_rd_valid2 <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sel       <= w_sel_nxt;
         r_rd_valid1 <= 1'b0;
         r_rd_valid2 <= 1'b0;
         if (r_state == ACCESS) begin
            r_rr   <= client_e'(r_sel + 2'd1);
            r_wait <= '0;
            r_kill <= w_clr_sel;
         end else if (r_state == RD_WAIT) begin
            r_wait <= r_wait + 8'd1;
            r_kill <= r_kill | w_clr_sel;
            // A ring cleared while its read is in flight drops the stale word.
            if (w_rd_done && !(r_kill || w_clr_sel)) begin
               if (is_ring2(r_sel)) begin
                  r_rd_data2  <= mem_rdata;
                  r_rd_valid2 <= 1'b1;
               end else begin
                  r_rd_data1  <= mem_rdata;
                  r_rd_valid1 <= 1'b1;
               end
            end
         end
      end
   end

   assign rd_data1  = r_rd_data1;
   assign rd_data2  = r_rd_data2;
   assign rd_valid1 = r_rd_valid1;
   assign rd_valid2 = r_rd_valid2;

endmodule
`default_nettype wire

// File: tb/tb_mem_ring_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ring_arbiter
// Description : Directed scoreboard bench for mem_ring_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ring_arbiter;

   localparam int L   = 2;
   localparam int R1S = 16'h00;
   localparam int R1E = 16'h7F;
   localparam int R2S = 16'h80;
   localparam int R2E = 16'hFF;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } bus_t;

   logic        clk, rst, clr1, clr2;
   logic        wr_req1, wr_req2, wr_ack1, wr_ack2;
   logic [15:0] wr_data1, wr_data2;
   logic        rd_req1, rd_req2, rd_ack1, rd_ack2, rd_valid1, rd_valid2;
   logic [15:0] rd_data1, rd_data2, count1, count2;
   logic        full1, full2, empty1, empty2;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;

   int n_checks = 0;
   int n_fail   = 0;

   bus_t        q_bus[$];
   logic [15:0] q_rd1[$];
   logic [15:0] q_rd2[$];
   logic [15:0] mm [0:255];
   int          m_wp1, m_rp1, m_cnt1, m_wp2, m_rp2, m_cnt2;

   logic [15:0] mem [0:255];
   logic [15:0] pa [0:L-1];
   logic [L-1:0] pv = '0;

   mem_ring_arbiter #(
      .RING1_START    (16'(R1S)),
      .RING1_END      (16'(R1E)),
      .RING2_START    (16'(R2S)),
      .RING2_END      (16'(R2E)),
      .MEM_RD_LATENCY (L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr1      (clr1),
      .clr2      (clr2),
      .wr_req1   (wr_req1),
      .wr_req2   (wr_req2),
      .wr_data1  (wr_data1),
      .wr_data2  (wr_data2),
      .wr_ack1   (wr_ack1),
      .wr_ack2   (wr_ack2),
      .rd_req1   (rd_req1),
      .rd_req2   (rd_req2),
      .rd_ack1   (rd_ack1),
      .rd_ack2   (rd_ack2),
      .rd_data1  (rd_data1),
      .rd_data2  (rd_data2),
      .rd_valid1 (rd_valid1),
      .rd_valid2 (rd_valid2),
      .count1    (count1),
      .count2    (count2),
      .full1     (full1),
      .full2     (full2),
      .empty1    (empty1),
      .empty2    (empty2),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory with a fixed read latency: data of the mem_re address appears L cycles later.
   always @(posedge clk) begin
      if (mem_we)
         mem[mem_addr[7:0]] <= mem_wdata;
      pa[0] <= mem_addr;
      pv    <= {pv[L-2:0], mem_re};
      for (int i = 1; i < L; i++)
         pa[i] <= pa[i-1];
   end
   assign mem_rdata = pv[L-1] ? mem[pa[L-1][7:0]] : 16'hDEAD;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Bus and read-data monitor pops the scoreboard whenever the DUT produces output.
   always @(negedge clk) begin
      bus_t e;
      if (mem_we || mem_re) begin
         chk("bus_mutex", 32'(mem_we & mem_re), 32'd0);
         if (q_bus.size() == 0)
            chk("bus_unexpected", 32'(q_bus.size()), 32'd1);
         else begin
            e = q_bus.pop_front();
            chk("bus_we", 32'(mem_we), 32'(e.we));
            chk("bus_addr", 32'(mem_addr), 32'(e.addr));
            if (e.we)
               chk("bus_wdata", 32'(mem_wdata), 32'(e.data));
         end
      end
      if (rd_valid1) begin
         if (q_rd1.size() == 0)
            chk("rd1_unexpected", 32'(q_rd1.size()), 32'd1);
         else
            chk("rd_data1", 32'(rd_data1), 32'(q_rd1.pop_front()));
      end
      if (rd_valid2) begin
         if (q_rd2.size() == 0)
            chk("rd2_unexpected", 32'(q_rd2.size()), 32'd1);
         else
            chk("rd_data2", 32'(rd_data2), 32'(q_rd2.pop_front()));
      end
   end

   function automatic int bump(input int p, input int s, input int e);
      return (p == e) ? s : p + 1;
   endfunction

   function automatic logic sig(input int k);
      case (k)
         0: return wr_ack1;
         1: return rd_ack1;
         2: return wr_ack2;
         3: return rd_ack2;
         4: return rd_valid1;
         5: return rd_valid2;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_wp1 = R1S; m_rp1 = R1S; m_cnt1 = 0;
      m_wp2 = R2S; m_rp2 = R2S; m_cnt2 = 0;
   endtask

   task automatic exp_wr(input int ring, input logic [15:0] d);
      int a;
      a = (ring == 1) ? m_wp1 : m_wp2;
      q_bus.push_back({1'b1, 16'(a), d});
      mm[a] = d;
      if (ring == 1) begin m_wp1 = bump(m_wp1, R1S, R1E); m_cnt1++; end
      else begin m_wp2 = bump(m_wp2, R2S, R2E); m_cnt2++; end
   endtask

   task automatic exp_rd(input int ring, input bit killed);
      int a;
      a = (ring == 1) ? m_rp1 : m_rp2;
      q_bus.push_back({1'b0, 16'(a), 16'h0000});
      if (!killed) begin
         if (ring == 1) q_rd1.push_back(mm[a]);
         else q_rd2.push_back(mm[a]);
      end
      if (ring == 1) begin m_rp1 = bump(m_rp1, R1S, R1E); m_cnt1--; end
      else begin m_rp2 = bump(m_rp2, R2S, R2E); m_cnt2--; end
   endtask

   task automatic wait_sig(input int k, output int n);
      logic found;
      n = 0;
      found = 1'b0;
      while (!found && n < 60) begin
         @(negedge clk);
         n++;
         found = sig(k);
      end
      if (!found)
         chk($sformatf("timeout_sig%0d", k), 32'(found), 32'd1);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      wr_req1 = 1'b0; wr_req2 = 1'b0; rd_req1 = 1'b0; rd_req2 = 1'b0;
      clr1 = 1'b0; clr2 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic do_write(input int ring, input logic [15:0] d);
      int n;
      exp_wr(ring, d);
      if (ring == 1) begin wr_data1 = d; wr_req1 = 1'b1; end
      else begin wr_data2 = d; wr_req2 = 1'b1; end
      wait_sig((ring == 1) ? 0 : 2, n);
      @(posedge clk); #1;
      if (ring == 1) wr_req1 = 1'b0; else wr_req2 = 1'b0;
   endtask

   task automatic do_read(input int ring, output int lat);
      exp_rd(ring, 1'b0);
      if (ring == 1) rd_req1 = 1'b1; else rd_req2 = 1'b1;
      wait_sig((ring == 1) ? 1 : 3, lat);
      @(posedge clk); #1;
      if (ring == 1) rd_req1 = 1'b0; else rd_req2 = 1'b0;
      wait_sig((ring == 1) ? 4 : 5, lat);
   endtask

   initial begin
      int n, seen;
      logic [3:0] pend, hit;
      wr_data1 = '0; wr_data2 = '0;
      reset_dut();

      // Reset state.
      @(negedge clk);
      chk("rst_count1", 32'(count1), 32'd0);
      chk("rst_count2", 32'(count2), 32'd0);
      chk("rst_flags", 32'({empty1, full1, empty2, full2}), 32'b1010);
      chk("rst_mem_ctl", 32'({mem_we, mem_re, wr_ack1, rd_ack1, rd_valid1, rd_valid2}), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_rd_data", 32'({rd_data1, rd_data2}), 32'd0);

      // Single write then read on ring 1.
      do_write(1, 16'hEFAB);
      chk("w1_count1", 32'(count1), 32'(m_cnt1));
      chk("w1_empty1", 32'(empty1), 32'd0);
      do_read(1, n);
      chk("rd_latency", 32'(n), 32'(L + 1));
      chk("rd_data1_at_valid", 32'(rd_data1), 32'h0000EFAB);
      chk("r1_count1", 32'(count1), 32'(m_cnt1));

      // Read on empty ring 2 is held off until a write lands.
      rd_req2 = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rd_ack2) seen++;
      end
      chk("empty2_no_ack", 32'(seen), 32'd0);
      exp_wr(2, 16'h9D4D);
      exp_rd(2, 1'b0);
      wr_data2 = 16'h9D4D;
      wr_req2 = 1'b1;
      wait_sig(2, n);
      @(posedge clk); #1 wr_req2 = 1'b0;
      wait_sig(3, n);
      @(posedge clk); #1 rd_req2 = 1'b0;
      wait_sig(5, n);
      chk("r2_count2", 32'(count2), 32'(m_cnt2));

      // All four requests high out of reset: grant order by scoreboard.
      rst = 1'b1;
      model_reset();
      exp_wr(1, 16'h1111);
      exp_rd(1, 1'b0);
      exp_wr(2, 16'h2222);
      exp_rd(2, 1'b0);
      wr_data1 = 16'h1111; wr_data2 = 16'h2222;
      wr_req1 = 1'b1; rd_req1 = 1'b1; wr_req2 = 1'b1; rd_req2 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      pend = 4'b1111;
      n = 0;
      while (pend != 4'b0000 && n < 60) begin
         @(negedge clk);
         n++;
         hit = {rd_ack2, wr_ack2, rd_ack1, wr_ack1} & pend;
         if (hit != 4'b0000) begin
            @(posedge clk); #1;
            if (hit[0]) wr_req1 = 1'b0;
            if (hit[1]) rd_req1 = 1'b0;
            if (hit[2]) wr_req2 = 1'b0;
            if (hit[3]) rd_req2 = 1'b0;
            pend = pend & ~hit;
         end
      end
      chk("all4_granted", 32'(pend), 32'd0);
      wait_sig(5, n);

      // Fill ring 1; extra write waits for a read, then wraps to START.
      reset_dut();
      for (int i = 0; i < 128; i++)
         do_write(1, 16'h1000 + 16'(i));
      chk("fill_count1", 32'(count1), 32'h80);
      chk("fill_full1", 32'(full1), 32'd1);
      wr_data1 = 16'hABCD;
      wr_req1 = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (wr_ack1) seen++;
      end
      chk("full_no_wr_ack", 32'(seen), 32'd0);
      exp_rd(1, 1'b0);
      exp_wr(1, 16'hABCD);
      rd_req1 = 1'b1;
      wait_sig(1, n);
      @(posedge clk); #1 rd_req1 = 1'b0;
      wait_sig(0, n);
      @(posedge clk); #1 wr_req1 = 1'b0;
      chk("wrap_count1", 32'(count1), 32'(m_cnt1));
      chk("wrap_full1", 32'(full1), 32'd1);

      // Clear during the read wait drops rd_valid1 and rewinds the ring.
      exp_rd(1, 1'b1);
      rd_req1 = 1'b1;
      wait_sig(1, n);
      @(posedge clk); #1 rd_req1 = 1'b0;
      clr1 = 1'b1;
      @(posedge clk); #1 clr1 = 1'b0;
      m_wp1 = R1S; m_rp1 = R1S; m_cnt1 = 0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (rd_valid1) seen++;
      end
      chk("clr_no_valid1", 32'(seen), 32'd0);
      chk("clr_count1", 32'(count1), 32'(m_cnt1));
      chk("clr_empty1", 32'(empty1), 32'd1);
      do_write(1, 16'h5A5A);
      chk("clr_wr_count1", 32'(count1), 32'(m_cnt1));

      // Reset asserted during the ACCESS cycle of a write.
      exp_wr(1, 16'h7777);
      wr_data1 = 16'h7777;
      wr_req1 = 1'b1;
      wait_sig(0, n);
      rst = 1'b1;
      @(posedge clk); #1 wr_req1 = 1'b0;
      model_reset();
      @(negedge clk);
      chk("arst_ctl", 32'({mem_we, mem_re, wr_ack1, rd_valid1}), 32'd0);
      chk("arst_addr", 32'(mem_addr), 32'd0);
      chk("arst_count1", 32'(count1), 32'(m_cnt1));
      chk("arst_empty1", 32'(empty1), 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(negedge clk);

      chk("bus_q_left", 32'(q_bus.size()), 32'd0);
      chk("rd_q_left", 32'(q_rd1.size() + q_rd2.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
